// File: rtl/io_sched_pkg.sv
// Shared types and helpers for the io_out slot scheduler.
// SCHED_PREEMPT_EN (consumed by io_slot_scheduler) enables the burst limit.
package io_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

  localparam logic [7:0] IDLE_VALUE_DEF = 8'h00;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/io_slot_scheduler_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above rr_ptr,
// wrapping, found by a priority encode over {req, req masked to >= rr_ptr}.
module rr_pick
  import io_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic               valid,
  output logic [PW-1:0]      winner
);

  logic [NUM_REQ-1:0]   hi_mask_s;
  logic [2*NUM_REQ-1:0] dbl_s;

  // Masked upper copy first so requests at/above the pointer beat wrapped ones.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask_s[i] = (PW'(i) >= rr_ptr);
    end
    dbl_s  = {req, req & hi_mask_s};
    valid  = |req;
    winner = '0;
    for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
      winner = dbl_s[i] ? ((i >= NUM_REQ) ? PW'(i - NUM_REQ) : PW'(i)) : winner;
    end
  end

endmodule

// File: rtl/io_slot_scheduler.sv
// Round-robin owner of the shared 8-bit io_out bank with idle gaps between owners.
// Define SCHED_PREEMPT_EN to release an owner after MAX_BURST granted cycles.
module io_slot_scheduler
  import io_sched_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter int         MAX_BURST  = 16,
  parameter int         GAP_CYCLES = 1,
  parameter logic [7:0] IDLE_VALUE = IDLE_VALUE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           io_out
);

  localparam int PW = clog2_safe(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = clog2_safe(GAP_CYCLES + 1);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic [7:0]         io_out_q, io_out_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic               pick_valid_s;
  logic [PW-1:0]      pick_winner_s;
  logic               own_req_s;
  logic [7:0]         own_data_s;
  logic               release_s;
  logic [PW-1:0]      owner_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // Owner's request and data, selected through the one-hot grant.
  always_comb begin
    own_req_s  = |(req & grant_q);
    own_data_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_data_s = own_data_s | (req_data[8*i +: 8] & {8{grant_q[i]}});
    end
    owner_s = grant_id_q[PW-1:0];
`ifdef SCHED_PREEMPT_EN
    release_s = !own_req_s || (burst_cnt_q == BW'(MAX_BURST));
`else
    release_s = !own_req_s;
`endif
  end

  // Next-state and registered-output logic for the IDLE/GRANT/GAP FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
    io_out_d    = io_out_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d                = GRANT;
          grant_d                = '0;
          grant_d[pick_winner_s] = 1'b1;
          grant_id_d             = 3'(pick_winner_s);
          busy_d                 = 1'b1;
          burst_cnt_d            = BW'(1);
        end else begin
          io_out_d = IDLE_VALUE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          io_out_d  = IDLE_VALUE;
          rr_ptr_d  = (owner_s == PW'(NUM_REQ - 1)) ? '0 : owner_s + PW'(1);
          gap_cnt_d = GW'(GAP_CYCLES);
        end else begin
          io_out_d    = own_data_s;
          // Saturating: the count only matters when the burst limit is built in.
          burst_cnt_d = (burst_cnt_q == {BW{1'b1}}) ? burst_cnt_q : burst_cnt_q + BW'(1);
        end
      end
      GAP: begin
        io_out_d = IDLE_VALUE;
        if (gap_cnt_q <= GW'(1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        io_out_d = IDLE_VALUE;
      end
    endcase
  end

  // State and output registers; reset drives io_out to the idle value without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_id_q  <= 3'd0;
      busy_q      <= 1'b0;
      io_out_q    <= IDLE_VALUE;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      io_out_q    <= io_out_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_io_slot_scheduler.sv
// Self-checking bench for io_slot_scheduler: directed table, corner sequences,
// and randomized traffic against a behavioural owner/cooldown model.
module tb_io_slot_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int MAX_BURST  = 16;
  localparam int GAP_CYCLES = 1;
`ifdef SCHED_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   grant;
  logic [2:0]           grant_id;
  logic                 busy;
  logic [7:0]           io_out;

  int tests = 0;
  int failed = 0;

  io_slot_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .MAX_BURST  (MAX_BURST),
    .GAP_CYCLES (GAP_CYCLES),
    .IDLE_VALUE (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .io_out   (io_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: owner index (-1 = none), cooldown cycles left, pointer.
  int         m_owner, m_last, m_ptr, m_run, m_cool;
  logic [7:0] m_io;

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_run = 0; m_cool = 0; m_io = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] d);
    if (m_owner >= 0) begin
      if (!r[m_owner] || (PREEMPT && m_run == MAX_BURST)) begin
        m_ptr = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
        m_io = 8'h00;
        m_cool = GAP_CYCLES;
      end else begin
        m_io = d[8*m_owner +: 8];
        m_run++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % NUM_REQ]) begin
          m_owner = (m_ptr + k) % NUM_REQ;
          m_last = m_owner;
          m_run = 1;
        end
      end
    end
  endtask

  function automatic logic [15:0] model_exp();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, 3'(m_last), (m_owner >= 0), m_io};
  endfunction

  task automatic check_out(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {grant, grant_id, busy, io_out};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b io=%h, want grant=%b id=%0d busy=%b io=%h",
               name, act[15:12], act[11:9], act[8], act[7:0],
               exp[15:12], exp[11:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, advance model, check after the next posedge.
  task automatic step(input string name, input logic [3:0] r, input logic [31:0] d);
    req = r;
    req_data = d;
    model_step(r, d);
    @(negedge clk);
    check_out(name, model_exp());
    tests++;
    if ($countones(grant) > 1) begin
      failed++;
      $display("FAIL onehot: got grant=%b, want at most one bit set", grant);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    req_data = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_out("reset_hold", {4'b0000, 3'd0, 1'b0, 8'h00});
    end
    rst_n = 1'b1;
    req = '0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [2:0]  gid;
    logic        busy;
    logic [7:0]  io;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int order[$];
    int gaps[$];
    int zero_run, count, k;
    logic prev_busy, done;
    logic [3:0] r;
    logic [3:0] want;

    vecs[0]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 3'd2, 1'b1, 8'h00};
    vecs[1]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 3'd2, 1'b1, 8'hA5};
    vecs[2]  = '{4'b0000, 32'h00A5_0000, 4'b0000, 3'd2, 1'b0, 8'h00};
    vecs[3]  = '{4'b0000, 32'h0000_0000, 4'b0000, 3'd2, 1'b0, 8'h00};
    vecs[4]  = '{4'b0001, 32'h0000_003C, 4'b0001, 3'd0, 1'b1, 8'h00};
    vecs[5]  = '{4'b0001, 32'h0000_003C, 4'b0001, 3'd0, 1'b1, 8'h3C};
    vecs[6]  = '{4'b1001, 32'h7700_003C, 4'b0001, 3'd0, 1'b1, 8'h3C};
    vecs[7]  = '{4'b1000, 32'h7700_003C, 4'b0000, 3'd0, 1'b0, 8'h00};
    vecs[8]  = '{4'b1000, 32'h7700_0000, 4'b0000, 3'd0, 1'b0, 8'h00};
    vecs[9]  = '{4'b1000, 32'h7700_0000, 4'b1000, 3'd3, 1'b1, 8'h00};
    vecs[10] = '{4'b1000, 32'h7700_0000, 4'b1000, 3'd3, 1'b1, 8'h77};

    // Reset with all requests high, then the directed table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = vecs[i].req;
      req_data = vecs[i].data;
      @(negedge clk);
      check_out($sformatf("table_%0d", i),
                {vecs[i].grant, vecs[i].gid, vecs[i].busy, vecs[i].io});
    end

    // Fairness: all request, each drops after 3 granted cycles.
    do_reset();
    prev_busy = 1'b0;
    zero_run = 0;
    for (int i = 0; i < 26; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_run >= 3) r[m_owner] = 1'b0;
      step("fair", r, $urandom);
      if (busy) begin
        if (!prev_busy) begin
          order.push_back(int'(grant_id));
          if (order.size() > 1) gaps.push_back(zero_run);
        end
        zero_run = 0;
      end else begin
        zero_run++;
      end
      prev_busy = busy;
    end
    check_int("fair_grants", (order.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check_int($sformatf("fair_order_%0d", i), order[i], i % 4);
    end
    // Release edge plus GAP_CYCLES gap edges leave grant low for GAP_CYCLES+1 cycles.
    for (int i = 0; i < 4; i++) begin
      if (i < gaps.size()) check_int($sformatf("fair_gap_%0d", i), gaps[i], GAP_CYCLES + 1);
    end

    // Burst: req=0011 held.
    do_reset();
    step("burst_first", 4'b0011, 32'h0000_2211);
    count = (grant == 4'b0001) ? 1 : 0;
    done = 1'b0;
    while (!done && count < 100) begin
      step("burst", 4'b0011, 32'h0000_2211);
      if (grant == 4'b0001) count++;
      else done = 1'b1;
    end
    check_int("burst_len_owner0", count, PREEMPT ? MAX_BURST : 100);
    for (int i = 0; i < 40; i++) step("burst_tail", 4'b0011, 32'h0000_2211);

    // Mid-grant asynchronous reset during owner 3.
    do_reset();
    for (int i = 0; i < 3; i++) step("own3", 4'b1000, 32'hE100_0000);
    check_out("own3_active", {4'b1000, 3'd3, 1'b1, 8'hE1});
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", {4'b0000, 3'd0, 1'b0, 8'h00});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 4'b1010, 32'h4400_3300);
    check_out("post_reset_low", {4'b0010, 3'd1, 1'b1, 8'h00});

    // Owner 1 drops req on the cycle its burst count reaches MAX_BURST.
    do_reset();
    step("sim_grant", 4'b0010, 32'h0000_5500);
    k = 0;
    while (m_run < MAX_BURST && k < 40) begin
      step("sim_hold", 4'b0010, 32'h0000_5500);
      k++;
    end
    step("sim_drop", 4'b0000, 32'h0000_5500);
    step("sim_gap", 4'b1111, 32'h0403_0201);
    step("sim_next", 4'b1111, 32'h0403_0201);
    check_out("sim_next_owner2", {4'b0100, 3'd2, 1'b1, 8'h00});

    // Randomized traffic against the model.
    do_reset();
    want = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NUM_REQ; b++) begin
        if ($urandom_range(0, 7) == 0) want[b] = ~want[b];
      end
      step("random", want, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
